// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: issues one cache access per memory instruction,
// stalls the pipeline until the cache responds, and returns the packet with mdrreg_out filled.
package rv32i_types;
    typedef struct packed {
        logic       mem;
        logic       data_mem_read;
        logic       data_mem_write;
        logic [3:0] data_mem_byte_enable;
        logic       regfile_write;
    } rv32i_ctrl_t;
endpackage

package rv32i_packet;
    import rv32i_types::*;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] mdrreg_out;
    } rv32i_data_t;
    typedef struct packed {
        rv32i_ctrl_t ctrl;
        rv32i_data_t data;
    } rv32i_packet_t;
endpackage

module mem_stage_ctrl
    import rv32i_types::*;
    import rv32i_packet::*;
(
    input  logic          clk,
    input  logic          rst,
    input  rv32i_packet_t pkt_i,
    input  logic          valid_i,
    input  logic          advance_i,
    output rv32i_packet_t pkt_o,
    output logic          stall_o,
    output logic          misalign_o,
    output logic          data_read,
    output logic          data_write,
    output logic [3:0]    data_mbe,
    output logic [31:0]   data_addr,
    output logic [31:0]   data_wdata,
    input  logic [31:0]   data_rdata,
    input  logic          data_resp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        data_read_q, data_read_d;
    logic        data_write_q, data_write_d;
    logic [3:0]  data_mbe_q, data_mbe_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] mdr_q, mdr_d;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic        req;
    logic        misaligned;
    logic        aligned_req;
    logic [3:0]  mbe_shift;
    logic [31:0] wdata_shift;

    always_comb begin
        off         = pkt_i.data.alu_out[1:0];
        mask        = pkt_i.ctrl.data_mem_byte_enable;
        req         = valid_i & pkt_i.ctrl.mem
                      & (pkt_i.ctrl.data_mem_read | pkt_i.ctrl.data_mem_write);
        mbe_shift   = mask << off;
        wdata_shift = pkt_i.data.rs2_out << {off, 3'b000};
        misaligned  = req & (((mask == 4'b0011) & (off == 2'd3))
                           | ((mask == 4'b1111) & (off != 2'd0)));
        aligned_req = req & ~misaligned;
    end

    always_comb begin
        state_d      = state_q;
        data_read_d  = data_read_q;
        data_write_d = data_write_q;
        data_mbe_d   = data_mbe_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        mdr_d        = mdr_q;
        case (state_q)
            IDLE: begin
                if (aligned_req) begin
                    state_d      = BUSY;
                    data_read_d  = pkt_i.ctrl.data_mem_read;
                    data_write_d = pkt_i.ctrl.data_mem_write;
                    data_mbe_d   = mbe_shift;
                    data_addr_d  = {pkt_i.data.alu_out[31:2], 2'b00};
                    data_wdata_d = wdata_shift;
                end
            end
            BUSY: begin
                if (data_resp) begin
                    state_d      = DONE;
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    if (data_read_q) begin
                        mdr_d = data_rdata;
                    end
                end
            end
            DONE: begin
                // Held here until the pipeline moves so the access is never re-issued
                if (advance_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                data_read_d  = 1'b0;
                data_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_read_q  <= 1'b0;
            data_write_q <= 1'b0;
            data_mbe_q   <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            mdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            data_read_q  <= data_read_d;
            data_write_q <= data_write_d;
            data_mbe_q   <= data_mbe_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            mdr_q        <= mdr_d;
        end
    end

    always_comb begin
        stall_o    = aligned_req & (state_q != DONE);
        misalign_o = misaligned;
        data_read  = data_read_q;
        data_write = data_write_q;
        data_mbe   = data_mbe_q;
        data_addr  = data_addr_q;
        data_wdata = data_wdata_q;
        pkt_o      = pkt_i;
        if (aligned_req & pkt_i.ctrl.data_mem_read) begin
            pkt_o.data.mdrreg_out = mdr_q;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases with literal expectations, then randomized
// traffic against a transaction-level model of the MEM stage and a latency-randomized cache.
module tb_mem_stage_ctrl;
    import rv32i_types::*;
    import rv32i_packet::*;

    logic          clk = 1'b0;
    logic          rst;
    rv32i_packet_t pkt_i;
    logic          valid_i;
    logic          advance_i;
    rv32i_packet_t pkt_o;
    logic          stall_o;
    logic          misalign_o;
    logic          data_read;
    logic          data_write;
    logic [3:0]    data_mbe;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic [31:0]   data_rdata;
    logic          data_resp;

    mem_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_i      (pkt_i),
        .valid_i    (valid_i),
        .advance_i  (advance_i),
        .pkt_o      (pkt_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_resp  (data_resp)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: an access is either outstanding at the cache, already served for the
    // instruction currently held, or neither.
    bit          m_outst  = 1'b0;
    bit          m_served = 1'b0;
    bit          m_isrd, m_iswr;
    logic [31:0] m_mdr    = '0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mbe;
    int          m_wait, m_lat;
    bit          exp_stall_now;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] m);
        case (m)
            4'b0001: return 1;
            4'b0011: return 2;
            default: return 4;
        endcase
    endfunction

    task automatic classify(output bit req, output bit mis);
        int off, n;
        req = valid_i && pkt_i.ctrl.mem && (pkt_i.ctrl.data_mem_read || pkt_i.ctrl.data_mem_write);
        off = int'(pkt_i.data.alu_out[1:0]);
        n   = nbytes(pkt_i.ctrl.data_mem_byte_enable);
        mis = req && (off + n > 4);
    endtask

    task automatic compare_model();
        bit req, mis;
        rv32i_packet_t ep;
        classify(req, mis);
        exp_stall_now = req && !mis && !m_served;
        chk("misalign", misalign_o, mis);
        chk("stall", stall_o, exp_stall_now);
        chk("data_read", data_read, m_outst && m_isrd);
        chk("data_write", data_write, m_outst && m_iswr);
        if (m_outst) begin
            chk("data_addr", data_addr, m_addr);
            chk("data_mbe", data_mbe, m_mbe);
            chk("data_wdata", data_wdata, m_wdata);
        end
        ep = pkt_i;
        if (req && !mis && pkt_i.ctrl.data_mem_read) ep.data.mdrreg_out = m_mdr;
        chk("pkt_o", pkt_o, ep);
    endtask

    task automatic model_step();
        bit req, mis;
        int off, n;
        classify(req, mis);
        if (rst) begin
            m_outst  = 1'b0;
            m_served = 1'b0;
            m_mdr    = '0;
        end else if (m_outst) begin
            if (data_resp) begin
                m_outst  = 1'b0;
                m_served = 1'b1;
                if (m_isrd) m_mdr = data_rdata;
            end else begin
                m_wait++;
            end
        end else if (m_served) begin
            if (advance_i) m_served = 1'b0;
        end else if (req && !mis) begin
            off     = int'(pkt_i.data.alu_out[1:0]);
            n       = nbytes(pkt_i.ctrl.data_mem_byte_enable);
            m_outst = 1'b1;
            m_isrd  = pkt_i.ctrl.data_mem_read;
            m_iswr  = pkt_i.ctrl.data_mem_write;
            m_addr  = pkt_i.data.alu_out & 32'hFFFF_FFFC;
            m_mbe   = 4'(((1 << n) - 1) << off);
            m_wdata = pkt_i.data.rs2_out << (8 * off);
            m_wait  = 0;
            m_lat   = int'($urandom_range(1, 5));
        end
    endtask

    task automatic neg();
        @(negedge clk);
        compare_model();
    endtask

    task automatic pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic rv32i_packet_t mk(input bit mem, input bit rd, input bit wr,
                                         input logic [3:0] be, input logic [31:0] alu,
                                         input logic [31:0] rs2);
        rv32i_packet_t p;
        p.ctrl.mem                  = mem;
        p.ctrl.data_mem_read        = rd;
        p.ctrl.data_mem_write       = wr;
        p.ctrl.data_mem_byte_enable = be;
        p.ctrl.regfile_write        = rd | ~mem;
        p.data.pc                   = $urandom;
        p.data.alu_out              = alu;
        p.data.rs2_out              = rs2;
        p.data.mdrreg_out           = $urandom;
        return p;
    endfunction

    function automatic rv32i_packet_t rand_pkt();
        int unsigned kind;
        logic [3:0] be;
        kind = $urandom_range(0, 7);
        case ($urandom_range(0, 2))
            0:       be = 4'b0001;
            1:       be = 4'b0011;
            default: be = 4'b1111;
        endcase
        if (kind < 2)
            return mk(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
        else if (kind == 7)
            return mk(1'b1, 1'b0, 1'b0, be, $urandom, $urandom);
        else if (kind < 5)
            return mk(1'b1, 1'b1, 1'b0, be, $urandom, $urandom);
        else
            return mk(1'b1, 1'b0, 1'b1, be, $urandom, $urandom);
    endfunction

    initial begin
        bit load_next;
        rst        = 1'b1;
        valid_i    = 1'b0;
        advance_i  = 1'b0;
        data_resp  = 1'b0;
        data_rdata = '0;
        pkt_i      = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        pos();
        pos();
        rst = 1'b0;

        // Reset state
        neg();
        chk("rst_read", data_read, 1'b0);
        chk("rst_write", data_write, 1'b0);
        chk("rst_mbe", data_mbe, 4'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_stall", stall_o, 1'b0);
        pos();

        // LW 0x1004, one-cycle cache
        pkt_i   = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_1004, $urandom);
        valid_i = 1'b1;
        neg();
        chk("lw_c0_stall", stall_o, 1'b1);
        chk("lw_c0_read", data_read, 1'b0);
        pos();
        data_resp  = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        neg();
        chk("lw_c1_read", data_read, 1'b1);
        chk("lw_c1_addr", data_addr, 32'h0000_1004);
        chk("lw_c1_mbe", data_mbe, 4'b1111);
        chk("lw_c1_stall", stall_o, 1'b1);
        pos();
        data_resp = 1'b0;
        advance_i = 1'b1;
        neg();
        chk("lw_c2_stall", stall_o, 1'b0);
        chk("lw_c2_mdr", pkt_o.data.mdrreg_out, 32'hDEAD_BEEF);
        chk("lw_c2_read", data_read, 1'b0);
        pos();

        // SB 0x2003
        pkt_i     = mk(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_2003, 32'h0000_00AB);
        advance_i = 1'b0;
        neg();
        pos();
        data_resp = 1'b1;
        neg();
        chk("sb_write", data_write, 1'b1);
        chk("sb_mbe", data_mbe, 4'b1000);
        chk("sb_wdata", data_wdata, 32'hAB00_0000);
        chk("sb_addr", data_addr, 32'h0000_2000);
        pos();
        data_resp = 1'b0;
        advance_i = 1'b1;
        neg();
        pos();

        // SH 0x3001
        pkt_i     = mk(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_3001, 32'h0000_1234);
        advance_i = 1'b0;
        neg();
        pos();
        data_resp = 1'b1;
        neg();
        chk("sh_mbe", data_mbe, 4'b0110);
        chk("sh_wdata", data_wdata, 32'h0012_3400);
        pos();
        data_resp = 1'b0;
        advance_i = 1'b1;
        neg();
        pos();

        // Misaligned LW 0x4002
        pkt_i     = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_4002, $urandom);
        advance_i = 1'b0;
        neg();
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_stall", stall_o, 1'b0);
        pos();
        neg();
        chk("mis_noreq", data_read, 1'b0);
        pos();
        advance_i = 1'b1;
        neg();
        pos();

        // LW with cache latency 5, then DONE held for 3 cycles
        pkt_i     = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0010, $urandom);
        advance_i = 1'b0;
        neg();
        pos();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                data_resp  = 1'b1;
                data_rdata = 32'h5A5A_A5A5;
            end
            neg();
            chk("lat5_read", data_read, 1'b1);
            chk("lat5_addr", data_addr, 32'h0000_0010);
            pos();
        end
        data_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("hold_read", data_read, 1'b0);
            chk("hold_stall", stall_o, 1'b0);
            chk("hold_mdr", pkt_o.data.mdrreg_out, 32'h5A5A_A5A5);
            pos();
        end
        advance_i = 1'b1;
        neg();
        pos();

        // Reset during BUSY, then an ADD packet
        pkt_i     = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, $urandom);
        advance_i = 1'b0;
        neg();
        pos();
        rst = 1'b1;
        neg();
        chk("rbusy_read", data_read, 1'b1);
        pos();
        rst       = 1'b0;
        pkt_i     = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0042, 32'h0000_0007);
        advance_i = 1'b1;
        neg();
        chk("add_read", data_read, 1'b0);
        chk("add_stall", stall_o, 1'b0);
        chk("add_alu", pkt_o.data.alu_out, 32'h0000_0042);
        pos();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            neg();
            load_next = advance_i && !exp_stall_now;
            pos();
            rst = ($urandom_range(0, 79) == 0);
            if (load_next) begin
                valid_i = ($urandom_range(0, 9) != 0);
                pkt_i   = rand_pkt();
            end
            advance_i  = ($urandom_range(0, 2) != 0);
            data_rdata = $urandom;
            if (m_outst) data_resp = (m_wait + 1 >= m_lat);
            else         data_resp = ($urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage data-memory controller for the pipelined RV32I core. Sits between the EX/MEM and MEM/WB pipeline buffers. Consumes the MEM fields of the control packet produced by ID (`data_mem_read`, `data_mem_write`, `data_mem_byte_enable`) and drives the data-cache handshake. Stalls the pipeline until the access completes, then returns the packet with `data.mdrreg_out` filled in.

## Interface
Parameters: none; all widths come from `rv32i_types` and `rv32i_packet`.

- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `pkt_i`  in  `rv32i_packet_t`  packet held in the EX/MEM buffer
- `valid_i`  in  1  `pkt_i` holds a real instruction; 0 means bubble
- `advance_i`  in  1  global pipeline load; the MEM/WB buffer captures `pkt_o` this cycle
- `pkt_o`  out  `rv32i_packet_t`  packet toward the MEM/WB buffer
- `stall_o`  out  1  MEM is busy; the hazard unit must hold all upstream buffers
- `misalign_o`  out  1  the current access is misaligned and was suppressed
- `data_read`  out  1  cache read request
- `data_write`  out  1  cache write request
- `data_mbe`  out  4  shifted byte mask
- `data_addr`  out  32  word-aligned address, equal to `{alu_out[31:2], 2'b00}`
- `data_wdata`  out  32  shifted store data
- `data_rdata`  in  32  cache read data, valid when `data_resp`=1
- `data_resp`  in  1  one-cycle completion pulse from the cache

## Operation

**Request condition.** `req = valid_i & ctrl.mem & (data_mem_read | data_mem_write)`.

**Byte lane shifting.** `ctrl.data_mem_byte_enable` is unshifted: 0001 for byte, 0011 for half, 1111 for word.
- `off = alu_out[1:0]`
- `data_mbe = mask << off`
- `data_wdata = rs2_out << (8*off)`

**Misalignment.**
- A half access with `off`=3 is misaligned.
- A word access with `off`≠0 is misaligned.
- A misaligned access:
  - issues no memory request;
  - drives `misalign_o`=1 combinationally;
  - sets `stall_o`=0;
  - passes the packet through unchanged.

**FSM states.** The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - If `req` is true and the access is aligned, go to BUSY.
  - At that edge, register `data_read`/`data_write` from the ctrl bits, and register `data_mbe`, `data_addr` and `data_wdata`.
- **BUSY**
  - Hold all memory outputs constant.
  - On `data_resp`:
    - capture `data_rdata` into the internal `mdr` (reads only);
    - deassert `data_read`/`data_write` on the next edge;
    - go to DONE.
- **DONE**
  - No memory request is active.
  - If `advance_i`=1, go to IDLE; otherwise stay in DONE.

**`stall_o`.** `stall_o = req & aligned & (state != DONE)`. It is combinational, so it is asserted in the same cycle the request first appears.

**`pkt_o`.** `pkt_o` equals `pkt_i`, except that `data.mdrreg_out` = `mdr` when the packet is a read. Load extraction and sign extension stay in regfilemux, not here.

**Non-memory packets and bubbles.** These pass through combinationally with `stall_o`=0, and the FSM stays in IDLE.

**Write-only accesses.** `mdr` is not updated, and `mdrreg_out` passes through unchanged.

## Timing

**Reset values.** All of these are 0: state = IDLE, `data_read`, `data_write`, `data_mbe`, `data_addr`, `data_wdata`, `mdr`.
- `stall_o` follows its combinational equation, so it may be 1 immediately after reset if `req` is present.

**Latency** (access first presented in cycle 0, cache answers `data_resp` in cycle k ≥ 1):
- cycle 0: `stall_o`=1, no memory request yet.
- cycles 1..k: `data_read` or `data_write` = 1.
- cycle k+1: state DONE, `stall_o`=0, `pkt_o.data.mdrreg_out` = captured data. The packet advances at the end of this cycle if `advance_i`=1.
- Minimum MEM occupancy is 3 cycles when k=1.

**Handshake rules.**
- The request stays high and stable until `data_resp`.
- Exactly one request is issued per instruction.
- `data_resp` seen while in IDLE or DONE is ignored.
- `pkt_i` is stable during BUSY, because `stall_o` holds the upstream buffers.

**Boundary conditions.**
- **Back-to-back memory instructions:** DONE with `advance_i`=1 returns to IDLE. The new `req` is then seen in the next cycle, giving one stall cycle before its request.
- **DONE with `advance_i`=0** (stall from another source): hold DONE and `mdr`, and never re-issue the access.
- **`rst` during BUSY:** the next edge drops the request and returns to IDLE. The cache is assumed to be reset by the same `rst`.
- **`data_resp` and `advance_i` in the same cycle while BUSY:** go to DONE. `advance_i` is don't-care because `stall_o` was 1.

## Test plan

- **LW, `alu_out`=0x0000_1004, one-cycle cache:**
  - `data_read`=1 with `data_addr`=0x1004 and `data_mbe`=1111 in cycle 1;
  - `data_resp` in cycle 1 with `data_rdata`=0xDEADBEEF;
  - `stall_o` = 1,1,0 over cycles 0..2;
  - `pkt_o.data.mdrreg_out`=0xDEADBEEF in cycle 2.
- **SB, `alu_out`=0x2003, `rs2_out`=0x0000_00AB:** `data_write`=1, `data_mbe`=1000, `data_wdata`=0xAB00_0000, `data_addr`=0x2000.
- **SH, `alu_out`=0x3001, `rs2_out`=0x1234:** `data_mbe`=0110, `data_wdata`=0x0012_3400.
- **LW with `alu_out`=0x4002:** no request issued, `misalign_o`=1, `stall_o`=0.
- **Cache latency 5 with `advance_i` held 0 for 3 cycles after DONE:**
  - request stays stable for 5 cycles;
  - the FSM stays in DONE with no second request.
- **Reset in BUSY, then an ADD packet:**
  - `data_read` drops after the reset edge;
  - the ADD packet passes through with `stall_o`=0.
